// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with a unified word-addressed memory and EX-stage branches.
// Latency: result in Reg four cycles after fetch; EX/MEM and MEM/WB forwarding, no load-use interlock.
// Backpressure: none; fetch stops only on HLT in ID, and a taken branch squashes IF/ID and ID/EX.
module pipe_mips32 #(
    parameter int MEM_WORDS = 1024
) (
    input logic clk,
    input logic rst_n
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef struct packed {
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
    } ifid_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
    } idex_t;

    typedef struct packed {
        logic        wr;
        logic        ld;
        logic        st;
        logic        hlt;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] stdat;
    } exmem_t;

    typedef struct packed {
        logic        wr;
        logic        hlt;
        logic [4:0]  dest;
        logic [31:0] dat;
    } memwb_t;

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        r_halt_pend;
    ifid_t       r_ifid;
    idex_t       r_idex;
    exmem_t      r_exmem;
    memwb_t      r_memwb;

    logic [31:0] w_fetch_ir;
    logic [4:0]  w_id_rs;
    logic [4:0]  w_id_rt;
    logic [31:0] w_id_a;
    logic [31:0] w_id_b;
    logic        w_id_hlt;
    logic        w_stall;
    logic [4:0]  w_ex_rs;
    logic [4:0]  w_ex_rt;
    logic [4:0]  w_ex_rd;
    logic [31:0] w_ex_imm;
    logic [31:0] w_fa;
    logic [31:0] w_fb;
    logic        w_taken;
    logic [31:0] w_target;
    logic [AW-1:0] w_mem_addr;
    logic [31:0] w_mem_rdat;
    ifid_t       w_ifid_nxt;
    idex_t       w_idex_nxt;
    exmem_t      w_exmem_nxt;
    memwb_t      w_memwb_nxt;

    // IF
    assign w_fetch_ir = Mem[PC[AW-1:0]];

    always_comb begin
        w_ifid_nxt     = '0;
        w_ifid_nxt.vld = 1'b1;
        w_ifid_nxt.ir  = w_fetch_ir;
        w_ifid_nxt.npc = PC + 32'd1;
    end

    // ID: register read with same-cycle write-back bypass
    assign w_id_rs = r_ifid.ir[25:21];
    assign w_id_rt = r_ifid.ir[20:16];
    assign w_id_a  = (r_memwb.wr && r_memwb.dest == w_id_rs) ? r_memwb.dat : Reg[w_id_rs];
    assign w_id_b  = (r_memwb.wr && r_memwb.dest == w_id_rt) ? r_memwb.dat : Reg[w_id_rt];

    assign w_id_hlt = r_ifid.vld && (r_ifid.ir[31:26] == OP_HLT) && !w_taken;
    assign w_stall  = HALTED || r_halt_pend || w_id_hlt;

    always_comb begin
        w_idex_nxt     = '0;
        w_idex_nxt.vld = r_ifid.vld;
        w_idex_nxt.ir  = r_ifid.ir;
        w_idex_nxt.npc = r_ifid.npc;
        w_idex_nxt.a   = w_id_a;
        w_idex_nxt.b   = w_id_b;
    end

    // EX: operand forwarding; a load in EX/MEM is not yet usable
    assign w_ex_rs  = r_idex.ir[25:21];
    assign w_ex_rt  = r_idex.ir[20:16];
    assign w_ex_rd  = r_idex.ir[15:11];
    assign w_ex_imm = {{16{r_idex.ir[15]}}, r_idex.ir[15:0]};
    assign w_target = r_idex.npc + w_ex_imm;

    always_comb begin
        w_fa = r_idex.a;
        if (r_exmem.wr && !r_exmem.ld && r_exmem.dest == w_ex_rs) begin
            w_fa = r_exmem.alu;
        end else if (r_memwb.wr && r_memwb.dest == w_ex_rs) begin
            w_fa = r_memwb.dat;
        end
    end

    always_comb begin
        w_fb = r_idex.b;
        if (r_exmem.wr && !r_exmem.ld && r_exmem.dest == w_ex_rt) begin
            w_fb = r_exmem.alu;
        end else if (r_memwb.wr && r_memwb.dest == w_ex_rt) begin
            w_fb = r_memwb.dat;
        end
    end

    always_comb begin
        w_exmem_nxt       = '0;
        w_taken           = 1'b0;
        w_exmem_nxt.stdat = w_fb;
        case (r_idex.ir[31:26])
            OP_ADD:   begin w_exmem_nxt.alu = w_fa + w_fb; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rd; end
            OP_SUB:   begin w_exmem_nxt.alu = w_fa - w_fb; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rd; end
            OP_AND:   begin w_exmem_nxt.alu = w_fa & w_fb; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rd; end
            OP_OR:    begin w_exmem_nxt.alu = w_fa | w_fb; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rd; end
            OP_SLT:   begin
                w_exmem_nxt.alu  = {31'd0, ($signed(w_fa) < $signed(w_fb))};
                w_exmem_nxt.wr   = 1'b1;
                w_exmem_nxt.dest = w_ex_rd;
            end
            OP_MUL:   begin w_exmem_nxt.alu = w_fa * w_fb; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rd; end
            OP_LW:    begin
                w_exmem_nxt.alu  = w_fa + w_ex_imm;
                w_exmem_nxt.wr   = 1'b1;
                w_exmem_nxt.ld   = 1'b1;
                w_exmem_nxt.dest = w_ex_rt;
            end
            OP_SW:    begin w_exmem_nxt.alu = w_fa + w_ex_imm; w_exmem_nxt.st = 1'b1; end
            OP_ADDI:  begin w_exmem_nxt.alu = w_fa + w_ex_imm; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rt; end
            OP_SUBI:  begin w_exmem_nxt.alu = w_fa - w_ex_imm; w_exmem_nxt.wr = 1'b1; w_exmem_nxt.dest = w_ex_rt; end
            OP_SLTI:  begin
                w_exmem_nxt.alu  = {31'd0, ($signed(w_fa) < $signed(w_ex_imm))};
                w_exmem_nxt.wr   = 1'b1;
                w_exmem_nxt.dest = w_ex_rt;
            end
            OP_BNEQZ: w_taken = (w_fa != 32'd0);
            OP_BEQZ:  w_taken = (w_fa == 32'd0);
            OP_HLT:   w_exmem_nxt.hlt = 1'b1;
            default:  ;
        endcase
        if (w_exmem_nxt.dest == 5'd0) begin
            w_exmem_nxt.wr = 1'b0;
        end
        if (!r_idex.vld) begin
            w_exmem_nxt = '0;
            w_taken     = 1'b0;
        end
    end

    // MEM
    assign w_mem_addr = r_exmem.alu[AW-1:0];
    assign w_mem_rdat = Mem[w_mem_addr];

    always_comb begin
        w_memwb_nxt      = '0;
        w_memwb_nxt.wr   = r_exmem.wr;
        w_memwb_nxt.hlt  = r_exmem.hlt;
        w_memwb_nxt.dest = r_exmem.dest;
        w_memwb_nxt.dat  = r_exmem.ld ? w_mem_rdat : r_exmem.alu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_ifid       <= '0;
            r_idex       <= '0;
            r_exmem      <= '0;
            r_memwb      <= '0;
        end else begin
            TAKEN_BRANCH <= w_taken;
            if (w_id_hlt) begin
                r_halt_pend <= 1'b1;
            end
            if (r_memwb.hlt) begin
                HALTED <= 1'b1;
            end
            if (w_taken) begin
                PC <= w_target;
            end else if (!w_stall) begin
                PC <= PC + 32'd1;
            end
            r_ifid  <= (w_taken || w_stall) ? '0 : w_ifid_nxt;
            r_idex  <= w_taken ? '0 : w_idex_nxt;
            r_exmem <= w_exmem_nxt;
            r_memwb <= w_memwb_nxt;
        end
    end

    // Architectural storage is never reset so preloaded programs survive a reset.
    always_ff @(posedge clk) begin
        if (r_memwb.wr && !HALTED) begin
            Reg[r_memwb.dest] <= r_memwb.dat;
        end
    end

    always_ff @(posedge clk) begin
        if (r_exmem.st && !HALTED) begin
            Mem[w_mem_addr] <= r_exmem.stdat;
        end
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: preloads programs hierarchically, runs each to HALTED and
// checks registers/memory against an expected-value table drained through a scoreboard queue.
`timescale 1ns/1ps
module tb_pipe_mips32;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_mips32 #(.MEM_WORDS(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    typedef struct {
        int          prog;
        string       name;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t        vec[$];
    vec_t        sb[$];
    int          r2_q[$];
    int          checks = 0;
    int          errors = 0;
    int          taken_cnt;
    bit          mon_en = 1'b0;
    logic [31:0] r2_prev;
    logic [31:0] reg_snap [32];
    logic [31:0] mem_snap [1024];
    logic [31:0] pc_snap;

    localparam logic [31:0] HLT = 32'hfc000000;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {op, s, t, d, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    function automatic vec_t mk(input int p, input string n, input bit m, input int i, input logic [31:0] e);
        vec_t v;
        v.prog = p; v.name = n; v.is_mem = m; v.idx = i; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
        case (p)
            0: begin
                dut.Mem[0]  = 32'h280a00c8; dut.Mem[1]  = 32'h28020001; dut.Mem[2]  = 32'h0e94a000;
                dut.Mem[3]  = 32'h21430000; dut.Mem[4]  = 32'h0e94a000; dut.Mem[5]  = 32'h14431000;
                dut.Mem[6]  = 32'h2c630001; dut.Mem[7]  = 32'h0e94a000; dut.Mem[8]  = 32'h3460fffc;
                dut.Mem[9]  = 32'h2542fffe; dut.Mem[10] = HLT;
                dut.Mem[200] = 32'd7;
            end
            1: begin
                dut.Mem[0] = enc_i(6'b001010, 0, 1, 16'd10);
                dut.Mem[1] = enc_i(6'b001010, 0, 2, 16'd20);
                dut.Mem[2] = enc_i(6'b001010, 0, 3, 16'd25);
                dut.Mem[3] = enc_r(6'b000000, 1, 2, 4);
                dut.Mem[4] = enc_r(6'b000000, 4, 3, 5);
                dut.Mem[5] = HLT;
            end
            2: begin
                dut.Mem[120] = 32'd85;
                dut.Mem[0] = enc_i(6'b001010, 0, 1, 16'd120);
                dut.Mem[1] = enc_i(6'b001000, 1, 2, 16'd0);
                dut.Mem[2] = enc_r(6'b000011, 20, 20, 20);
                dut.Mem[3] = enc_i(6'b001010, 2, 2, 16'd45);
                dut.Mem[4] = enc_i(6'b001001, 1, 2, 16'd1);
                dut.Mem[5] = HLT;
            end
            3: begin
                dut.Mem[0] = enc_i(6'b001110, 0, 0, 16'd2);
                dut.Mem[1] = enc_i(6'b001010, 0, 5, 16'd9);
                dut.Mem[2] = enc_i(6'b001010, 0, 6, 16'd9);
                dut.Mem[3] = enc_i(6'b001010, 0, 7, 16'd3);
                dut.Mem[4] = HLT;
            end
            default: begin
                dut.Mem[300] = 32'd1000;
                dut.Mem[0]  = enc_i(6'b001010, 0, 1, 16'hfffb);
                dut.Mem[1]  = enc_i(6'b001010, 0, 2, 16'd14);
                dut.Mem[2]  = enc_r(6'b000001, 2, 1, 3);
                dut.Mem[3]  = enc_r(6'b000010, 2, 3, 4);
                dut.Mem[4]  = enc_r(6'b000100, 1, 2, 5);
                dut.Mem[5]  = enc_i(6'b001100, 2, 6, 16'hffff);
                dut.Mem[6]  = enc_i(6'b001011, 1, 7, 16'd10);
                dut.Mem[7]  = enc_r(6'b000101, 1, 2, 8);
                dut.Mem[8]  = enc_i(6'b001000, 0, 9, 16'd300);
                dut.Mem[9]  = enc_r(6'b000000, 9, 0, 10);
                dut.Mem[10] = enc_r(6'b000000, 9, 0, 11);
                dut.Mem[11] = enc_i(6'b001101, 0, 0, 16'd5);
                dut.Mem[12] = enc_i(6'b001001, 0, 7, 16'hffff);
                dut.Mem[13] = enc_i(6'b001010, 0, 0, 16'd77);
                dut.Mem[14] = enc_i(6'b010101, 0, 12, 16'd5);
                dut.Mem[15] = HLT;
            end
        endcase
    endtask

    task automatic queue_expect(input int p);
        foreach (vec[i]) if (vec[i].prog == p) sb.push_back(vec[i]);
    endtask

    task automatic drain();
        vec_t v;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            chk(v.name, v.is_mem ? dut.Mem[v.idx] : dut.Reg[v.idx], v.exp);
        end
    endtask

    task automatic run_to_halt(input int budget, output int n);
        n = 0;
        while (dut.HALTED !== 1'b1 && n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
        end
        chk("halt_reached", {31'd0, dut.HALTED}, 32'd1);
    endtask

    task automatic snap();
        pc_snap = dut.PC;
        for (int i = 0; i < 32; i++) reg_snap[i] = dut.Reg[i];
        for (int i = 0; i < 1024; i++) mem_snap[i] = dut.Mem[i];
    endtask

    task automatic cmp_snap(input string tag);
        int rd, md;
        rd = 0; md = 0;
        for (int i = 0; i < 32; i++) if (dut.Reg[i] !== reg_snap[i]) rd++;
        for (int i = 0; i < 1024; i++) if (dut.Mem[i] !== mem_snap[i]) md++;
        chk({tag, "_reg_diffs"}, rd, 32'd0);
        chk({tag, "_mem_diffs"}, md, 32'd0);
    endtask

    // R2 value sequence monitor for the factorial run
    always @(negedge clk) begin
        if (mon_en && dut.Reg[2] !== r2_prev) begin
            if (r2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r2_seq_extra: got %0d expected no further change", dut.Reg[2]);
            end else begin
                chk("r2_seq", dut.Reg[2], r2_q.pop_front());
            end
            r2_prev = dut.Reg[2];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        vec.push_back(mk(0, "fact_r2",     0, 2,   32'd5040));
        vec.push_back(mk(0, "fact_r3",     0, 3,   32'd0));
        vec.push_back(mk(0, "fact_r10",    0, 10,  32'd200));
        vec.push_back(mk(0, "fact_m198",   1, 198, 32'd5040));
        vec.push_back(mk(1, "fwd_r1",      0, 1,   32'd10));
        vec.push_back(mk(1, "fwd_r4",      0, 4,   32'd30));
        vec.push_back(mk(1, "fwd_r5",      0, 5,   32'd55));
        vec.push_back(mk(2, "ls_r1",       0, 1,   32'd120));
        vec.push_back(mk(2, "ls_r2",       0, 2,   32'd130));
        vec.push_back(mk(2, "ls_m121",     1, 121, 32'd130));
        vec.push_back(mk(2, "ls_m120",     1, 120, 32'd85));
        vec.push_back(mk(3, "br_r5",       0, 5,   32'd5));
        vec.push_back(mk(3, "br_r6",       0, 6,   32'd6));
        vec.push_back(mk(3, "br_r7",       0, 7,   32'd3));
        vec.push_back(mk(4, "alu_r1",      0, 1,   32'hfffffffb));
        vec.push_back(mk(4, "alu_sub_r3",  0, 3,   32'd19));
        vec.push_back(mk(4, "alu_and_r4",  0, 4,   32'd2));
        vec.push_back(mk(4, "alu_slt_r5",  0, 5,   32'd1));
        vec.push_back(mk(4, "alu_slti_r6", 0, 6,   32'd0));
        vec.push_back(mk(4, "alu_subi_r7", 0, 7,   32'hfffffff1));
        vec.push_back(mk(4, "alu_mul_r8",  0, 8,   32'hffffffba));
        vec.push_back(mk(4, "alu_lw_r9",   0, 9,   32'd1000));
        vec.push_back(mk(4, "loaduse_r10", 0, 10,  32'd9));
        vec.push_back(mk(4, "load2_r11",   0, 11,  32'd1000));
        vec.push_back(mk(4, "r0_write",    0, 0,   32'd0));
        vec.push_back(mk(4, "nop_r12",     0, 12,  32'd12));
        vec.push_back(mk(4, "wrap_m1023",  1, 1023, 32'hfffffff1));

        // Reset state and first fetch
        rst_n = 1'b0;
        load_prog(0);
        queue_expect(0);
        r2_q = '{1, 7, 42, 210, 840, 2520, 5040};
        #1;
        chk("reset_pc", dut.PC, 32'd0);
        chk("reset_halted", {31'd0, dut.HALTED}, 32'd0);
        chk("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        r2_prev = dut.Reg[2];
        mon_en  = 1'b1;
        @(posedge clk);
        #1;
        chk("first_fetch_pc", dut.PC, 32'd1);
        taken_cnt = 0;
        run_to_halt(1000, n);
        mon_en = 1'b0;
        chk("r2_seq_remaining", r2_q.size(), 32'd0);
        chk("fact_taken", taken_cnt, 32'd6);
        drain();

        // Frozen while halted
        snap();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("halt_pc_frozen", dut.PC, pc_snap);
        chk("halt_sticky", {31'd0, dut.HALTED}, 32'd1);
        cmp_snap("halt");

        // Reset after halt, then reset again mid-program
        rst_n = 1'b0;
        #1;
        chk("rst_after_halt_pc", dut.PC, 32'd0);
        chk("rst_after_halt_halted", {31'd0, dut.HALTED}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", dut.PC, 32'd0);
        chk("midrst_halted", {31'd0, dut.HALTED}, 32'd0);
        snap();
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_snap("midrst");
        rst_n = 1'b1;
        taken_cnt = 0;
        run_to_halt(1000, n);
        chk("rerun_r2", dut.Reg[2], 32'd5040);
        chk("rerun_m198", dut.Mem[198], 32'd5040);
        chk("rerun_taken", taken_cnt, 32'd6);

        // Remaining programs from the vector table
        for (int p = 1; p <= 4; p++) begin
            @(negedge clk);
            rst_n = 1'b0;
            load_prog(p);
            queue_expect(p);
            @(negedge clk);
            rst_n = 1'b1;
            taken_cnt = 0;
            run_to_halt(500, n);
            drain();
            if (p == 1) begin
                chk("fwd_halt_cycles", n, 32'd10);
                chk("fwd_halt_pc", dut.PC, 32'd6);
            end
            if (p == 3) chk("br_taken_once", taken_cnt, 32'd1);
            if (p == 4) chk("alu_no_taken", taken_cnt, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mips32.md
PIPE_MIPS32 -- requirements
Module: pipe_mips32

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, the number of 32-bit words in the unified instruction/data memory.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have no other ports; bench access is hierarchical to internal state named exactly: Reg (32x32 register file), Mem (MEM_WORDS x 32, word-addressed), PC (32-bit word address), HALTED (1 bit), TAKEN_BRANCH (1 bit).

Function
REQ-005 SHALL implement a 5-stage pipeline: IF, ID, EX, MEM, WB; one instruction fetched per cycle unless halted.
REQ-006 SHALL decode opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
REQ-007 SHALL support R-type, writing rd: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1/0), MUL 000101 (low 32 bits of product).
REQ-008 SHALL support I-type, writing rt: LW 001000 (rt=Mem[rs+imm]), ADDI 001010, SUBI 001011, SLTI 001100 (signed).
REQ-009 SHALL support SW 001001 (Mem[rs+imm]=rt), BNEQZ 001101, BEQZ 001110 (test rs against 0) and HLT 111111; any other opcode SHALL execute as a no-op.
REQ-010 SHALL form memory addresses from the low log2(MEM_WORDS) bits of the effective address; add/sub/mul wrap modulo 2^32.
REQ-011 SHALL ignore writes to R0; reads of R0 return Reg[0].
REQ-012 SHALL bypass WB write data to ID reads of the same register in the same cycle.
REQ-013 SHALL forward ALU results from EX/MEM and ALU/load results from MEM/WB into EX operands, youngest first; no interlock: a consumer one instruction after an LW reads the stale value, all other consumers at distance >=1 get correct values.
REQ-014 SHALL resolve branches in EX: target = (branch PC + 1) + imm; if taken, PC loads the target, the two younger in-flight instructions (IF/ID, ID/EX) are squashed (no register, memory or halt effect), and TAKEN_BRANCH is 1 for that cycle, else 0.
REQ-015 SHALL stop fetching (PC frozen, bubbles issued) once an unsquashed HLT is in ID, and set HALTED when that HLT reaches WB; older instructions complete normally.
REQ-016 SHALL make no change to PC, Reg or Mem while HALTED=1; HALTED stays 1 until reset.
REQ-017 SHALL perform SW writes in MEM and register writes in WB, one cycle each.

Reset
REQ-018 SHALL, while rst_n=0, force PC=0, HALTED=0, TAKEN_BRANCH=0 and all pipeline registers to bubbles, asynchronously.
REQ-019 SHALL NOT modify Reg or Mem on reset, so bench preloads survive; reset mid-program discards all in-flight instructions.
REQ-020 SHALL fetch Mem[0] on the first rising edge after rst_n rises.

Verification
REQ-021 Factorial: Reg[k]=k; Mem[0..10] = 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000; Mem[200]=7 -> R2 successive values 1,7,42,210,840,2520,5040; Mem[198]=5040; HALTED=1.
REQ-022 Forwarding: ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; ADD R4,R1,R2; ADD R5,R4,R3; HLT, no fillers -> R4=30, R5=55.
REQ-023 Load/store: Mem[120]=85; ADDI R1,R0,120; LW R2,0(R1); OR R20,R20,R20; ADDI R2,R2,45; SW R2,1(R1); HLT -> R2=130, Mem[121]=130.
REQ-024 Branch squash: BEQZ R0,+2; ADDI R5,R0,9; ADDI R6,R0,9; ADDI R7,R0,3; HLT -> R5, R6 unchanged, R7=3, TAKEN_BRANCH pulsed exactly once.
REQ-025 Halt/reset: after HALTED=1, run 20 cycles -> PC, Reg, Mem unchanged; pulse rst_n low mid-program -> PC=0, HALTED=0, Reg/Mem preserved, program reruns to the same results.
